// File: rtl/tick_scheduler.sv
// Clock-enable generator: pixel, millisecond and second strobes from the board clock.
// Divide ratios can be changed at run time; a change lands only on a tick boundary or while paused.
module tick_scheduler #(
    parameter int unsigned PIX_DIV = 4,
    parameter int unsigned MS_DIV  = 100000,
    parameter int unsigned S_TICKS = 1000,
    parameter int unsigned W       = 17
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic         cfg_sel,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         pix_tick,
    output logic         ms_tick,
    output logic         sec_tick,
    output logic [15:0]  sec_count
);

    localparam int unsigned SW = (S_TICKS > 1) ? $clog2(S_TICKS) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(S_TICKS - 1);

    typedef enum logic {
        IDLE,
        PEND
    } cfg_state_e;

    cfg_state_e  state_q, state_d;
    logic [W-1:0] pix_cnt_q, pix_cnt_d;
    logic [W-1:0] ms_cnt_q, ms_cnt_d;
    logic [W-1:0] pix_div_q, pix_div_d;
    logic [W-1:0] ms_div_q, ms_div_d;
    logic [SW-1:0] sub_cnt_q, sub_cnt_d;
    logic [15:0]  sec_count_q, sec_count_d;
    logic         pix_tick_q, pix_tick_d;
    logic         ms_tick_q, ms_tick_d;
    logic         sec_tick_q, sec_tick_d;
    logic         cfg_sel_q, cfg_sel_d;
    logic [W-1:0] cfg_div_q, cfg_div_d;

    logic [W-1:0] pix_last;
    logic [W-1:0] ms_last;
    logic         pix_wrap;
    logic         ms_wrap;
    logic         apply;

    // A ratio of 0 behaves like 1, so the last count is 0 in both cases.
    always_comb begin
        pix_last = (pix_div_q == '0) ? '0 : pix_div_q - W'(1);
        ms_last  = (ms_div_q == '0) ? '0 : ms_div_q - W'(1);
        pix_wrap = en && (pix_cnt_q >= pix_last);
        ms_wrap  = en && (ms_cnt_q >= ms_last);
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        ms_cnt_d    = ms_cnt_q;
        pix_div_d   = pix_div_q;
        ms_div_d    = ms_div_q;
        sub_cnt_d   = sub_cnt_q;
        sec_count_d = sec_count_q;
        pix_tick_d  = 1'b0;
        ms_tick_d   = 1'b0;
        sec_tick_d  = 1'b0;
        cfg_sel_d   = cfg_sel_q;
        cfg_div_d   = cfg_div_q;
        apply       = 1'b0;

        if (en) begin
            pix_cnt_d  = pix_wrap ? '0 : pix_cnt_q + W'(1);
            ms_cnt_d   = ms_wrap ? '0 : ms_cnt_q + W'(1);
            pix_tick_d = pix_wrap;
            ms_tick_d  = ms_wrap;
            if (ms_wrap) begin
                if (sub_cnt_q == SUB_LAST) begin
                    sub_cnt_d   = '0;
                    sec_tick_d  = 1'b1;
                    sec_count_d = sec_count_q + 16'd1;
                end else begin
                    sub_cnt_d = sub_cnt_q + SW'(1);
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_sel_d = cfg_sel;
                    cfg_div_d = cfg_div;
                    state_d   = PEND;
                end
            end
            PEND: begin
                apply = !en || (cfg_sel_q ? ms_wrap : pix_wrap);
                if (apply) begin
                    if (cfg_sel_q) begin
                        ms_div_d = cfg_div_q;
                        ms_cnt_d = '0;
                    end else begin
                        pix_div_d = cfg_div_q;
                        pix_cnt_d = '0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            ms_cnt_q    <= '0;
            pix_div_q   <= W'(PIX_DIV);
            ms_div_q    <= W'(MS_DIV);
            sub_cnt_q   <= '0;
            sec_count_q <= '0;
            pix_tick_q  <= 1'b0;
            ms_tick_q   <= 1'b0;
            sec_tick_q  <= 1'b0;
            cfg_sel_q   <= 1'b0;
            cfg_div_q   <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            ms_cnt_q    <= ms_cnt_d;
            pix_div_q   <= pix_div_d;
            ms_div_q    <= ms_div_d;
            sub_cnt_q   <= sub_cnt_d;
            sec_count_q <= sec_count_d;
            pix_tick_q  <= pix_tick_d;
            ms_tick_q   <= ms_tick_d;
            sec_tick_q  <= sec_tick_d;
            cfg_sel_q   <= cfg_sel_d;
            cfg_div_q   <= cfg_div_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign pix_tick  = pix_tick_q;
    assign ms_tick   = ms_tick_q;
    assign sec_tick  = sec_tick_q;
    assign sec_count = sec_count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: period-based reference model, directed scenarios, random traffic,
// and a second fast instance that walks sec_count through its 16-bit wrap.
module tb_tick_scheduler;

    localparam int W   = 17;
    localparam int PIX = 4;
    localparam int MSD = 10;
    localparam int ST  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clr, en, cfg_valid, cfg_sel;
    logic [W-1:0] cfg_div;
    logic         cfg_ready, pix_tick, ms_tick, sec_tick;
    logic [15:0]  sec_count;

    logic         clr2;
    logic         en2 = 1'b1;
    logic         cfg_valid2 = 1'b0;
    logic         cfg_sel2 = 1'b0;
    logic [W-1:0] cfg_div2 = '0;
    logic         cfg_ready2, pix_tick2, ms_tick2, sec_tick2;
    logic [15:0]  sec_count2;

    tick_scheduler #(.PIX_DIV(PIX), .MS_DIV(MSD), .S_TICKS(ST), .W(W)) dut (
        .clk(clk), .clr(clr), .en(en), .cfg_valid(cfg_valid),
        .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .pix_tick(pix_tick), .ms_tick(ms_tick), .sec_tick(sec_tick),
        .sec_count(sec_count)
    );

    tick_scheduler #(.PIX_DIV(1), .MS_DIV(1), .S_TICKS(1), .W(W)) dut2 (
        .clk(clk), .clr(clr2), .en(en2), .cfg_valid(cfg_valid2),
        .cfg_sel(cfg_sel2), .cfg_div(cfg_div2), .cfg_ready(cfg_ready2),
        .pix_tick(pix_tick2), .ms_tick(ms_tick2), .sec_tick(sec_tick2),
        .sec_count(sec_count2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each divider is described by how many enabled
    // edges have elapsed in its current period and the period length.
    int m_pix_div, m_ms_div, m_pix_ph, m_ms_ph, m_sub, m_sec;
    int m_psel, m_pdiv;
    bit m_pend, m_valid = 1'b0;
    bit e_pix, e_ms, e_sec;
    bit pf, mf, old_pend;
    int k2 = 0;
    bit v2 = 1'b0;

    function automatic int period(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_pix_div = PIX; m_ms_div = MSD;
            m_pix_ph = 0; m_ms_ph = 0; m_sub = 0; m_sec = 0;
            m_pend = 1'b0; e_pix = 1'b0; e_ms = 1'b0; e_sec = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            old_pend = m_pend;
            pf = 1'b0; mf = 1'b0; e_sec = 1'b0;
            if (en) begin
                m_pix_ph++;
                if (m_pix_ph >= period(m_pix_div)) begin m_pix_ph = 0; pf = 1'b1; end
                m_ms_ph++;
                if (m_ms_ph >= period(m_ms_div)) begin m_ms_ph = 0; mf = 1'b1; end
                if (mf) begin
                    m_sub++;
                    if (m_sub == ST) begin
                        m_sub = 0; e_sec = 1'b1; m_sec = (m_sec + 1) % 65536;
                    end
                end
            end
            e_pix = pf; e_ms = mf;
            if (old_pend) begin
                if (!en || (m_psel != 0 ? mf : pf)) begin
                    if (m_psel != 0) begin m_ms_div = m_pdiv; m_ms_ph = 0; end
                    else begin m_pix_div = m_pdiv; m_pix_ph = 0; end
                    m_pend = 1'b0;
                end
            end else if (cfg_valid) begin
                m_pend = 1'b1; m_psel = int'(cfg_sel); m_pdiv = int'(cfg_div);
            end
        end
        if (clr2) begin k2 = 0; v2 = 1'b1; end
        else if (v2) k2++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pix_tick", 32'(pix_tick), 32'(e_pix));
            chk("ms_tick", 32'(ms_tick), 32'(e_ms));
            chk("sec_tick", 32'(sec_tick), 32'(e_sec));
            chk("sec_count", 32'(sec_count), 32'(m_sec));
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        end
        if (v2) begin
            chk("f_sec_count", 32'(sec_count2), 32'(k2 % 65536));
            chk("f_sec_tick", 32'(sec_tick2), 32'(k2 >= 1));
            chk("f_ms_tick", 32'(ms_tick2), 32'(k2 >= 1));
            chk("f_pix_tick", 32'(pix_tick2), 32'(k2 >= 1));
            chk("f_ready", 32'(cfg_ready2), 32'd1);
            if (k2 == 65535) chk("f_pre_wrap", 32'(sec_count2), 32'hffff);
            if (k2 == 65536) chk("f_wrap", 32'(sec_count2), 32'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic sel, input int div);
        cfg_valid = 1'b1; cfg_sel = sel; cfg_div = W'(div);
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        clr = 1'b1; clr2 = 1'b1; en = 1'b0;
        cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_div = '0;
        cyc(2);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_pix", 32'(pix_tick), 32'd0);
        chk("rst_sec_count", 32'(sec_count), 32'd0);
        clr = 1'b0; clr2 = 1'b0; en = 1'b1;

        cyc(3);  chk("e3_pix", 32'(pix_tick), 32'd0);
        cyc(1);  chk("e4_pix", 32'(pix_tick), 32'd1);
        cyc(6);  chk("e10_ms", 32'(ms_tick), 32'd1);
        chk("e10_pix", 32'(pix_tick), 32'd0);
        cyc(2);  chk("e12_pix", 32'(pix_tick), 32'd1);
        cyc(37); chk("e49_sec_count", 32'(sec_count), 32'd0);
        cyc(1);  chk("e50_sec", 32'(sec_tick), 32'd1);
        chk("e50_sec_count", 32'(sec_count), 32'd1);
        chk("e50_ms", 32'(ms_tick), 32'd1);

        en = 1'b0;
        cyc(7);  chk("pause_sec_count", 32'(sec_count), 32'd1);
        en = 1'b1;
        cyc(1);  chk("resume1_pix", 32'(pix_tick), 32'd0);
        cyc(1);  chk("resume2_pix", 32'(pix_tick), 32'd1);

        cyc(1);
        send(1'b0, 6);
        chk("pend_ready", 32'(cfg_ready), 32'd0);
        cyc(1);  chk("pend_pix", 32'(pix_tick), 32'd0);
        chk("pend_ready2", 32'(cfg_ready), 32'd0);
        cyc(1);  chk("apply_pix", 32'(pix_tick), 32'd1);
        chk("apply_ready", 32'(cfg_ready), 32'd1);
        cyc(5);  chk("div6_gap", 32'(pix_tick), 32'd0);
        cyc(1);  chk("div6_tick", 32'(pix_tick), 32'd1);

        en = 1'b0;
        send(1'b1, 3);
        cyc(1);  chk("paused_apply", 32'(cfg_ready), 32'd1);
        en = 1'b1;
        cyc(2);  chk("ms3_gap", 32'(ms_tick), 32'd0);
        cyc(1);  chk("ms3_tick", 32'(ms_tick), 32'd1);
        cyc(3);  chk("ms3_tick2", 32'(ms_tick), 32'd1);

        send(1'b0, 0);
        cyc(8);
        for (int i = 0; i < 4; i++) begin
            cyc(1); chk("div0_pix", 32'(pix_tick), 32'd1);
        end
        send(1'b0, 1);
        cyc(3);
        for (int i = 0; i < 4; i++) begin
            cyc(1); chk("div1_pix", 32'(pix_tick), 32'd1);
        end

        send(1'b0, 9);
        clr = 1'b1;
        cyc(1);
        chk("clr_pend_ready", 32'(cfg_ready), 32'd1);
        clr = 1'b0;
        cyc(3);  chk("clr_pend_gap", 32'(pix_tick), 32'd0);
        cyc(1);  chk("clr_pend_div", 32'(pix_tick), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_sel = 1'($urandom_range(0, 1));
            cfg_div = W'($urandom_range(0, 12));
            clr = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        clr = 1'b0; cfg_valid = 1'b0; en = 1'b1;

        for (int i = 0; i < 70000 && k2 < 65540; i++) cyc(1);
        chk("f_run_done", 32'(k2 >= 65540), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
